// File: rtl/snake_row_scanner.sv
// Snake row scanner: walks the segment list from the head and builds a
// per-column occupancy mask, head flag and food flag for one grid row.
//
// Ports:
//   clk, rst_n_in               clock, async active-low reset
//   row_req_in, row_y_in        scan request and the row to scan
//   food_x_in, food_y_in        food cell, latched with the request
//   query_addr_out              segment index being queried (0 = head)
//   queried_segment_*_in        same-cycle answer for query_addr_out
//   row_busy_out                scan or publish in progress
//   row_ready_out               one-cycle pulse when results update
//   row_req_dropped_out         one-cycle pulse for a rejected request
//   row_body_mask_out           bit c set iff a segment is at (c, row)
//   row_head_hit_out/_col_out   head lies in the row, and its column
//   row_food_hit_out/_col_out   food lies in the row, and its column
module snake_row_scanner #(
    parameter int X        = 6,
    parameter int Y        = 5,
    parameter int S_ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst_n_in,
    input  logic                row_req_in,
    input  logic [Y-1:0]        row_y_in,
    input  logic [X-1:0]        food_x_in,
    input  logic [Y-1:0]        food_y_in,
    output logic [S_ADDR_W-1:0] query_addr_out,
    input  logic [X-1:0]        queried_segment_x_in,
    input  logic [Y-1:0]        queried_segment_y_in,
    input  logic                queried_segment_valid_in,
    output logic                row_busy_out,
    output logic                row_ready_out,
    output logic                row_req_dropped_out,
    output logic [2**X-1:0]     row_body_mask_out,
    output logic                row_head_hit_out,
    output logic [X-1:0]        row_head_col_out,
    output logic                row_food_hit_out,
    output logic [X-1:0]        row_food_col_out
);

    localparam logic [S_ADDR_W-1:0] LAST_ADDR = {S_ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PUBLISH
    } state_t;

    state_t             state;
    logic [Y-1:0]       row_q;
    logic [X-1:0]       food_x_q;
    logic [Y-1:0]       food_y_q;
    logic [2**X-1:0]    work_mask;
    logic               work_head;
    logic [X-1:0]       work_head_col;
    logic               seg_hit;

    assign seg_hit = queried_segment_valid_in
                   && (queried_segment_y_in == row_q);

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state               <= IDLE;
            row_q               <= '0;
            food_x_q            <= '0;
            food_y_q            <= '0;
            work_mask           <= '0;
            work_head           <= 1'b0;
            work_head_col       <= '0;
            query_addr_out      <= '0;
            row_busy_out        <= 1'b0;
            row_ready_out       <= 1'b0;
            row_req_dropped_out <= 1'b0;
            row_body_mask_out   <= '0;
            row_head_hit_out    <= 1'b0;
            row_head_col_out    <= '0;
            row_food_hit_out    <= 1'b0;
            row_food_col_out    <= '0;
        end else begin
            row_ready_out       <= 1'b0;
            row_req_dropped_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (row_req_in) begin
                        row_q          <= row_y_in;
                        food_x_q       <= food_x_in;
                        food_y_q       <= food_y_in;
                        work_mask      <= '0;
                        work_head      <= 1'b0;
                        query_addr_out <= '0;
                        row_busy_out   <= 1'b1;
                        state          <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_req_in) begin
                        row_req_dropped_out <= 1'b1;
                    end
                    if (seg_hit) begin
                        work_mask[queried_segment_x_in] <= 1'b1;
                        if (query_addr_out == '0) begin
                            work_head     <= 1'b1;
                            work_head_col <= queried_segment_x_in;
                        end
                    end
                    // Stop at the first invalid slot or the last index;
                    // the address is never wrapped back to the head.
                    if (queried_segment_valid_in
                        && (query_addr_out != LAST_ADDR)) begin
                        query_addr_out <= query_addr_out + 1'b1;
                    end else begin
                        state <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    if (row_req_in) begin
                        row_req_dropped_out <= 1'b1;
                    end
                    row_body_mask_out <= work_mask;
                    row_head_hit_out  <= work_head;
                    row_head_col_out  <= work_head_col;
                    row_food_hit_out  <= (food_y_q == row_q);
                    row_food_col_out  <= food_x_q;
                    row_ready_out     <= 1'b1;
                    row_busy_out      <= 1'b0;
                    query_addr_out    <= '0;
                    state             <= IDLE;
                end
                default: begin
                    row_busy_out   <= 1'b0;
                    query_addr_out <= '0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
